// File: rtl/smem_pkg.sv
// Shared definitions for the result-stream writer: line width, trailer tag,
// writer FSM states and the header field positions of the result format.
package smem_pkg;

    localparam int LINE_W = 512;
    localparam logic [31:0] TRAILER_MAGIC = 32'h5EE5_0001;

    // Field positions inside a read header line
    localparam int HDR_READ_NUM_LSB = 0;
    localparam int HDR_READ_NUM_MSB = 9;
    localparam int HDR_MEM_SIZE_LSB = 64;
    localparam int HDR_MEM_SIZE_MSB = 70;
    localparam int HDR_RET_LSB      = 128;
    localparam int HDR_RET_MSB      = 159;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_STREAM,
        ST_DRAIN,
        ST_TRAILER,
        ST_DONE
    } wr_state_t;

    // Trailer line: line count in [31:0], tag in [63:32], rest zero
    function automatic logic [LINE_W-1:0] make_trailer(input logic [31:0] count,
                                                       input logic [31:0] magic);
        logic [LINE_W-1:0] line;
        line        = '0;
        line[31:0]  = count;
        line[63:32] = magic;
        return line;
    endfunction

endpackage

// File: rtl/smem_sync_fifo.sv
// Single-clock FIFO with combinational head read; a push becomes visible at
// the head only after the clock edge that writes it.
module smem_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];

    // A push into a full FIFO succeeds when the same cycle pops
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/smem_result_writer.sv
// Drains the 512-bit result stream into host cache-line writes, throttles the
// pipeline via stall, and closes each batch with a counted trailer line.
module smem_result_writer #(
    parameter int          FIFO_DEPTH    = 16,
    parameter int          ADDR_W        = 32,
    parameter int          CNT_W         = 32,
    parameter logic [31:0] TRAILER_MAGIC = 32'h5EE5_0001
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        in_request,
    output logic                        in_permit,
    input  logic [smem_pkg::LINE_W-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_finish,
    output logic                        stall,
    output logic                        wr_valid,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [smem_pkg::LINE_W-1:0] wr_data,
    input  logic                        wr_ready,
    output logic                        done,
    output logic                        overflow,
    output logic [CNT_W-1:0]            lines_written
);

    import smem_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_state_t         state_q, state_d;
    logic              in_permit_q, in_permit_d;
    logic              stall_q, stall_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [LINE_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  lines_q, lines_d;
    logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LINE_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_count, count_next;
    logic              push_req, drop, wr_fire, out_free;

    smem_sync_fifo #(
        .WIDTH (LINE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_fire    = wr_valid_q && wr_ready;
    assign out_free   = !wr_valid_q || wr_ready;
    assign fifo_pop   = out_free && !fifo_empty &&
                        (state_q == ST_STREAM || state_q == ST_DRAIN);
    // Beats are only taken while the permit is held (including the finish cycle)
    assign push_req   = (state_q == ST_STREAM) && in_valid;
    assign fifo_push  = push_req && (!fifo_full || fifo_pop);
    assign drop       = push_req && fifo_full && !fifo_pop;
    assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    always_comb begin
        state_d    = state_q;
        addr_ptr_d = addr_ptr_q;
        lines_d    = lines_q;
        done_d     = done_q;
        overflow_d = overflow_q | drop;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (wr_fire) begin
            wr_valid_d = 1'b0;
            addr_ptr_d = addr_ptr_q + ADDR_W'(1);
            if (lines_q != '1) lines_d = lines_q + CNT_W'(1);
        end

        // The refilled line takes the address after any line retiring this cycle
        if (fifo_pop) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_ptr_d;
            wr_data_d  = fifo_head;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_WAIT_REQ;
                    addr_ptr_d = base_addr;
                    lines_d    = '0;
                    done_d     = 1'b0;
                end
            end
            ST_WAIT_REQ: begin
                if (in_request) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (in_finish) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && !wr_valid_q) state_d = ST_TRAILER;
            end
            ST_TRAILER: begin
                if (!wr_valid_q) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = addr_ptr_q;
                    wr_data_d  = make_trailer(32'(lines_q), TRAILER_MAGIC);
                end else if (wr_fire) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_permit_d = (state_d == ST_STREAM);
        stall_d     = (state_d == ST_STREAM || state_d == ST_DRAIN) &&
                      (count_next >= CW'(FIFO_DEPTH - 2));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            in_permit_q <= 1'b0;
            stall_q     <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            lines_q     <= '0;
            addr_ptr_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_permit_q <= in_permit_d;
            stall_q     <= stall_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            lines_q     <= lines_d;
            addr_ptr_q  <= addr_ptr_d;
        end
    end

    assign in_permit     = in_permit_q;
    assign stall         = stall_q;
    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign lines_written = lines_q;

endmodule

// File: tb/tb_smem_result_writer.sv
// Directed bench for smem_result_writer: table of batches plus hand-written
// overflow and mid-stream reset sequences, with a write-channel scoreboard.
module tb_smem_result_writer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [31:0]  base_addr;
    logic         in_request;
    logic         in_permit;
    logic [511:0] in_data;
    logic         in_valid;
    logic         in_finish;
    logic         stall;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready;
    logic         done;
    logic         overflow;
    logic [31:0]  lines_written;

    smem_result_writer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .in_request    (in_request),
        .in_permit     (in_permit),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_finish     (in_finish),
        .stall         (stall),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .done          (done),
        .overflow      (overflow),
        .lines_written (lines_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Batch records: stimulus and hand-computed expected results.
    // ready mode: 0 always ready, 1 toggling, 2 not ready for 25 cycles, 3 never ready
    typedef struct {
        logic [31:0] base;
        int          nbeats;
        int          mode;
        logic        exp_stall;
        int          exp_lines;
        logic [31:0] exp_trailer_addr;
    } vec_t;

    vec_t vecs [6];

    logic [31:0]  exp_addr [$];
    logic [511:0] exp_data [$];
    bit           sb_en = 1'b1;
    bit           stall_seen;
    int           ready_mode = 0;
    int           ready_cyc = 0;
    int           batch_id = 0;
    logic [31:0]  last_addr;
    bit           prev_hold = 1'b0;
    logic [31:0]  prev_addr;
    logic [511:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] beat_data(input int b, input int i);
        logic [511:0] d;
        for (int k = 0; k < 16; k++)
            d[k*32 +: 32] = {8'(b), 8'(i), 16'(k)} ^ 32'hC3A5_0000;
        return d;
    endfunction

    function automatic logic [511:0] trailer(input int n);
        logic [511:0] t;
        t = '0;
        t[31:0]  = 32'(n);
        t[63:32] = 32'h5EE5_0001;
        return t;
    endfunction

    // wr_ready driver
    always @(posedge clk) begin
        #1;
        ready_cyc++;
        case (ready_mode)
            0: wr_ready = 1'b1;
            1: wr_ready = ~wr_ready;
            2: wr_ready = (ready_cyc >= 25);
            default: wr_ready = 1'b0;
        endcase
    end

    // Write-channel monitor: hold stability and scoreboard
    always @(posedge clk) begin
        #2;
        if (stall) stall_seen = 1'b1;
        if (prev_hold && reset_n) begin
            checks++;
            if (!wr_valid || wr_addr !== prev_addr || wr_data !== prev_data) begin
                errors++;
                $display("FAIL hold_stable: got valid=%0b addr=%0h, expected valid=1 addr=%0h",
                         wr_valid, wr_addr, prev_addr);
            end
        end
        if (reset_n && wr_valid && wr_ready) begin
            last_addr = wr_addr;
            $display("write addr=%08h data[63:0]=%016h", wr_addr, wr_data[63:0]);
            if (sb_en) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h, expected no write", wr_addr);
                end else begin
                    logic [31:0]  ea;
                    logic [511:0] ed;
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    if (ea !== wr_addr || ed !== wr_data) begin
                        errors++;
                        $display("FAIL write_line: got addr=%0h data_lo=%0h, expected addr=%0h data_lo=%0h",
                                 wr_addr, wr_data[63:0], ea, ed[63:0]);
                    end
                end
            end
        end
        prev_hold = reset_n && wr_valid && !wr_ready;
        prev_addr = wr_addr;
        prev_data = wr_data;
    end

    task automatic start_batch(input logic [31:0] base, input int mode);
        ready_mode = mode;
        ready_cyc  = 0;
        stall_seen = 1'b0;
        base_addr  = base;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        in_request = 1'b1;
        for (int g = 0; g < 20 && !in_permit; g++) tick();
        chk("permit_granted", 64'(in_permit), 64'd1);
    endtask

    task automatic wait_done();
        for (int g = 0; g < 2000 && !done; g++) tick();
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic run_batch(input vec_t v);
        int rem;
        int idx;
        int guard;
        batch_id++;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < v.nbeats; i++) begin
            exp_addr.push_back(v.base + 32'(i));
            exp_data.push_back(beat_data(batch_id, i));
        end
        exp_addr.push_back(v.base + 32'(v.nbeats));
        exp_data.push_back(trailer(v.nbeats));

        start_batch(v.base, v.mode);
        rem   = v.nbeats;
        idx   = 0;
        guard = 0;
        while (in_permit && guard < 2000) begin
            in_valid  = 1'b0;
            in_finish = 1'b0;
            if (rem > 0 && !stall) begin
                in_valid  = 1'b1;
                in_data   = beat_data(batch_id, idx);
                in_finish = (rem == 1);
                idx++;
                rem--;
            end else if (rem == 0) begin
                in_finish = 1'b1;
            end
            tick();
            guard++;
        end
        in_valid   = 1'b0;
        in_finish  = 1'b0;
        in_request = 1'b0;

        wait_done();
        tick();
        chk("lines_written", 64'(lines_written), 64'(v.exp_lines));
        chk("trailer_addr", 64'(last_addr), 64'(v.exp_trailer_addr));
        chk("overflow_clear", 64'(overflow), 64'd0);
        chk("stall_idle", 64'(stall), 64'd0);
        chk("wr_valid_idle", 64'(wr_valid), 64'd0);
        chk("sb_empty", 64'(exp_addr.size()), 64'd0);
        chk("stall_seen", 64'(stall_seen), 64'(v.exp_stall));
    endtask

    initial begin
        vec_t post_rst;
        vecs[0] = '{32'h0000_1000,  3, 0, 1'b0,  4, 32'h0000_1003};
        vecs[1] = '{32'h0000_2000, 12, 2, 1'b0, 13, 32'h0000_200C};
        vecs[2] = '{32'h0000_3000, 15, 2, 1'b1, 16, 32'h0000_300F};
        vecs[3] = '{32'h0000_4000,  5, 1, 1'b0,  6, 32'h0000_4005};
        vecs[4] = '{32'h0000_5000,  0, 0, 1'b0,  1, 32'h0000_5000};
        vecs[5] = '{32'hFFFF_FFFE,  4, 1, 1'b0,  5, 32'h0000_0002};
        post_rst = '{32'h0000_9000, 3, 0, 1'b0,  4, 32'h0000_9003};

        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        in_request = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_finish  = 1'b0;
        wr_ready   = 1'b0;
        repeat (3) tick();
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_permit", 64'(in_permit), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lines", 64'(lines_written), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_permit", 64'(in_permit), 64'd0);
        chk("idle_stall", 64'(stall), 64'd0);

        for (int v = 0; v < 6; v++) run_batch(vecs[v]);

        // Overflow: ignore stall with the host never ready
        sb_en = 1'b0;
        batch_id++;
        start_batch(32'h0000_7000, 3);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = beat_data(batch_id, i);
            tick();
            if (i == 15) chk("ovf_not_yet", 64'(overflow), 64'd0);
        end
        chk("ovf_set", 64'(overflow), 64'd1);
        in_valid  = 1'b0;
        in_finish = 1'b1;
        tick();
        in_finish  = 1'b0;
        in_request = 1'b0;
        repeat (5) tick();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        ready_mode = 0;
        wait_done();
        chk("ovf_after_done", 64'(overflow), 64'd1);

        // Reset mid-stream: 5 beats in, host stalled, then async reset
        batch_id++;
        start_batch(32'h0000_8000, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = beat_data(batch_id, i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_wr_valid", 64'(wr_valid), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_wr_valid", 64'(wr_valid), 64'd0);
        chk("arst_permit", 64'(in_permit), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_wr_addr", 64'(wr_addr), 64'd0);
        chk("arst_wr_data_or", 64'(|wr_data), 64'd0);
        chk("arst_lines", 64'(lines_written), 64'd0);
        in_request = 1'b0;
        ready_mode = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        sb_en = 1'b1;
        run_batch(post_rst);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
